round_manager: RTL and testbench
================================

ROUND_MANAGER -- requirements
Module: round_manager

Interface
REQ-001 Parameter HEALTH_MAX, default 100, starting health of each player (7-bit, 1..127).
REQ-002 Parameter DAMAGE, default 10, health removed per accepted hit (1..127).
REQ-003 Parameter IFRAME_CYCLES, default 16, post-hit invulnerability window in clk cycles (1..255).
REQ-004 Parameter ROUND_SECS, default 99, round length in timer ticks (ROUND_TIMER_EN only).
REQ-005 Parameter TICK_CYCLES, default 50_000_000, clk cycles per timer tick (ROUND_TIMER_EN only).
REQ-006 clk  input  1  system clock, all logic rising-edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start_btn  input  1  synchronous raw start button, level.
REQ-009 one_hit  input  1  player 1 struck, from player-2 fireball opponent_hit; level, may be held multiple cycles.
REQ-010 two_hit  input  1  player 2 struck, from player-1 fireball opponent_hit; same rules.
REQ-011 start  output  1  one-cycle pulse driving start of both players and both fireballs.
REQ-012 one_health, two_health  output  7  current health.
REQ-013 round_state  output  2  0 IDLE, 1 FIGHT, 2 OVER.
REQ-014 winner  output  2  0 none, 1 player 1, 2 player 2, 3 draw.
REQ-015 time_left  output  8  remaining ticks; constant 0 without ROUND_TIMER_EN.

Function
REQ-016 Rising edges of start_btn, one_hit, two_hit SHALL be detected with one registered delay; only edges act.
REQ-017 IDLE: start_btn edge -> FIGHT next cycle; in that transition cycle start=1, both healths=HEALTH_MAX, winner=0, cooldowns=0, time_left=ROUND_SECS.
REQ-018 OVER: start_btn edge -> FIGHT with identical reload and start pulse; winner held until then.
REQ-019 start SHALL be 1 for exactly one cycle per round entry, else 0.
REQ-020 FIGHT: one_hit edge with player-1 cooldown 0 -> one_health -= DAMAGE, saturating at 0; cooldown loaded with IFRAME_CYCLES, decremented by 1 per cycle to 0.
REQ-021 Hit edges during nonzero cooldown, or outside FIGHT, SHALL be ignored.
REQ-022 two_hit handled identically and independently; simultaneous accepted edges apply both decrements in the same cycle.
REQ-023 Health update visible on the cycle after the registered edge (2-cycle latency from input rise).
REQ-024 Cycle in FIGHT where a health is 0 -> OVER next cycle; winner = 1 if only two_health=0, 2 if only one_health=0, 3 if both 0.
REQ-025 start_btn edge in FIGHT SHALL be ignored.
REQ-026 Healths SHALL never underflow or exceed HEALTH_MAX.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, start=0, winner=0, one_health=two_health=HEALTH_MAX, cooldowns=0, edge registers=0, time_left=0, tick counter=0, including mid-FIGHT.
REQ-028 An input held high across rst_n deassertion SHALL NOT produce an edge.

Configuration
REQ-029 Macro ROUND_TIMER_EN defined: in FIGHT a tick counter wraps every TICK_CYCLES cycles, decrementing time_left (not below 0); time_left=0 in FIGHT -> OVER next cycle, winner by higher health, 3 if equal; KO takes priority in the same cycle.
REQ-030 Macro undefined: no timer logic, time_left tied 0, rounds end only by KO.

Verification (HEALTH_MAX=100, DAMAGE=10, IFRAME_CYCLES=16, TICK_CYCLES=4 for test)
REQ-031 Reset then start_btn 0->1 -> start pulses 1 cycle, round_state=1, both healths 100.
REQ-032 one_hit held high 40 cycles -> one_health=90 exactly once; re-pulse after 16 cycles -> 80.
REQ-033 Ten spaced two_hit pulses -> two_health=0, round_state=2, winner=1; further hits no change.
REQ-034 Both healths 10, one_hit and two_hit rise same cycle -> both 0, winner=3.
REQ-035 rst_n low mid-FIGHT with one_health=50 -> immediate IDLE, healths 100, winner 0.
REQ-036 ROUND_TIMER_EN, ROUND_SECS=3, one_health=90, two_health=100 -> OVER after 12 cycles, winner=2.

Source files
------------

// File: rtl/round_manager.sv
// Two-player round controller: start/KO sequencing, health bookkeeping and post-hit invulnerability.
// Optional round timer enabled by defining ROUND_TIMER_EN; without it time_left is tied to 0.
module round_manager #(
    parameter int HEALTH_MAX    = 100,
    parameter int DAMAGE        = 10,
    parameter int IFRAME_CYCLES = 16,
    parameter int ROUND_SECS    = 99,
    parameter int TICK_CYCLES   = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       one_hit,
    input  logic       two_hit,
    output logic       start,
    output logic [6:0] one_health,
    output logic [6:0] two_health,
    output logic [1:0] round_state,
    output logic [1:0] winner,
    output logic [7:0] time_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIGHT = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam logic [6:0] HEALTH_FULL = 7'(HEALTH_MAX);
    localparam logic [6:0] DAMAGE_AMT  = 7'(DAMAGE);
    localparam logic [7:0] IFRAME_LEN  = 8'(IFRAME_CYCLES);

    state_t     state_q, next_state;
    logic       start_q, start_d;
    logic [6:0] one_health_q, one_health_d, two_health_q, two_health_d;
    logic [1:0] winner_q, winner_d;
    logic [7:0] one_cd_q, one_cd_d, two_cd_q, two_cd_d;

    logic armed_q;
    logic start_prev_q, one_prev_q, two_prev_q;
    logic start_edge_q, one_edge_q, two_edge_q;

`ifdef ROUND_TIMER_EN
    logic [7:0]  time_left_q, time_left_d;
    logic [31:0] tick_q, tick_d;
`else
    localparam int unused_timer_cfg = ROUND_SECS + TICK_CYCLES;
`endif

    // armed_q suppresses the first sample after reset so a level held across reset is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q      <= 1'b0;
            start_prev_q <= 1'b0;
            one_prev_q   <= 1'b0;
            two_prev_q   <= 1'b0;
            start_edge_q <= 1'b0;
            one_edge_q   <= 1'b0;
            two_edge_q   <= 1'b0;
        end else begin
            armed_q      <= 1'b1;
            start_prev_q <= start_btn;
            one_prev_q   <= one_hit;
            two_prev_q   <= two_hit;
            start_edge_q <= armed_q & start_btn & ~start_prev_q;
            one_edge_q   <= armed_q & one_hit & ~one_prev_q;
            two_edge_q   <= armed_q & two_hit & ~two_prev_q;
        end
    end

    always_comb begin
        next_state   = state_q;
        start_d      = 1'b0;
        one_health_d = one_health_q;
        two_health_d = two_health_q;
        winner_d     = winner_q;
        one_cd_d     = (one_cd_q != 8'd0) ? one_cd_q - 8'd1 : 8'd0;
        two_cd_d     = (two_cd_q != 8'd0) ? two_cd_q - 8'd1 : 8'd0;
`ifdef ROUND_TIMER_EN
        time_left_d  = time_left_q;
        tick_d       = tick_q;
`endif
        unique case (state_q)
            IDLE, OVER: begin
                if (start_edge_q) begin
                    next_state   = FIGHT;
                    start_d      = 1'b1;
                    one_health_d = HEALTH_FULL;
                    two_health_d = HEALTH_FULL;
                    winner_d     = 2'd0;
                    one_cd_d     = 8'd0;
                    two_cd_d     = 8'd0;
`ifdef ROUND_TIMER_EN
                    time_left_d  = 8'(ROUND_SECS);
                    tick_d       = 32'd0;
`endif
                end
            end
            FIGHT: begin
                // A KO outranks timer expiry; hits are frozen on the cycle the round ends
                if (one_health_q == 7'd0 || two_health_q == 7'd0) begin
                    next_state = OVER;
                    if (one_health_q == 7'd0 && two_health_q == 7'd0) winner_d = 2'd3;
                    else if (two_health_q == 7'd0)                  winner_d = 2'd1;
                    else                                            winner_d = 2'd2;
                end
`ifdef ROUND_TIMER_EN
                else if (time_left_q == 8'd0) begin
                    next_state = OVER;
                    if (one_health_q > two_health_q)      winner_d = 2'd1;
                    else if (two_health_q > one_health_q) winner_d = 2'd2;
                    else                                  winner_d = 2'd3;
                end
`endif
                else begin
                    if (one_edge_q && one_cd_q == 8'd0) begin
                        one_health_d = (one_health_q <= DAMAGE_AMT) ? 7'd0 : one_health_q - DAMAGE_AMT;
                        one_cd_d     = IFRAME_LEN;
                    end
                    if (two_edge_q && two_cd_q == 8'd0) begin
                        two_health_d = (two_health_q <= DAMAGE_AMT) ? 7'd0 : two_health_q - DAMAGE_AMT;
                        two_cd_d     = IFRAME_LEN;
                    end
`ifdef ROUND_TIMER_EN
                    if (tick_q == 32'(TICK_CYCLES - 1)) begin
                        tick_d = 32'd0;
                        if (time_left_q != 8'd0) time_left_d = time_left_q - 8'd1;
                    end else begin
                        tick_d = tick_q + 32'd1;
                    end
`endif
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            one_health_q <= HEALTH_FULL;
            two_health_q <= HEALTH_FULL;
            winner_q     <= 2'd0;
            one_cd_q     <= 8'd0;
            two_cd_q     <= 8'd0;
        end else begin
            state_q      <= next_state;
            start_q      <= start_d;
            one_health_q <= one_health_d;
            two_health_q <= two_health_d;
            winner_q     <= winner_d;
            one_cd_q     <= one_cd_d;
            two_cd_q     <= two_cd_d;
        end
    end

`ifdef ROUND_TIMER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_left_q <= 8'd0;
            tick_q      <= 32'd0;
        end else begin
            time_left_q <= time_left_d;
            tick_q      <= tick_d;
        end
    end
    assign time_left = time_left_q;
`else
    assign time_left = 8'd0;
`endif

    assign start       = start_q;
    assign one_health  = one_health_q;
    assign two_health  = two_health_q;
    assign round_state = state_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_round_manager.sv
// Directed bench for round_manager: reset, start pulse, i-frames, KO, draw, async reset and
// (when ROUND_TIMER_EN is defined) timer expiry. Inputs change on negedges, outputs sampled there.
module tb_round_manager;

    logic       clk;
    logic       rst_n;
    logic       start_btn;
    logic       one_hit;
    logic       two_hit;
    logic       start;
    logic [6:0] one_health;
    logic [6:0] two_health;
    logic [1:0] round_state;
    logic [1:0] winner;
    logic [7:0] time_left;

    int checks   = 0;
    int failures = 0;

    round_manager #(
        .HEALTH_MAX   (100),
        .DAMAGE       (10),
        .IFRAME_CYCLES(16),
        .ROUND_SECS   (3),
        .TICK_CYCLES  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_btn  (start_btn),
        .one_hit    (one_hit),
        .two_hit    (two_hit),
        .start      (start),
        .one_health (one_health),
        .two_health (two_health),
        .round_state(round_state),
        .winner     (winner),
        .time_left  (time_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_btn = 1'b0; one_hit = 1'b0; two_hit = 1'b0;
        tick(3);
        checks++; if (round_state !== 2'd0) begin failures++; $display("[TB] FAIL reset_state: got %0d expected 0", round_state); end
        checks++; if (start !== 1'b0) begin failures++; $display("[TB] FAIL reset_start: got %0d expected 0", start); end
        checks++; if (one_health !== 7'd100) begin failures++; $display("[TB] FAIL reset_one_health: got %0d expected 100", one_health); end
        checks++; if (two_health !== 7'd100) begin failures++; $display("[TB] FAIL reset_two_health: got %0d expected 100", two_health); end
        checks++; if (winner !== 2'd0) begin failures++; $display("[TB] FAIL reset_winner: got %0d expected 0", winner); end
        checks++; if (time_left !== 8'd0) begin failures++; $display("[TB] FAIL reset_time_left: got %0d expected 0", time_left); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_start();
        logic [7:0] exp_tl;
`ifdef ROUND_TIMER_EN
        exp_tl = 8'd3;
`else
        exp_tl = 8'd0;
`endif
        start_btn = 1'b1;
        tick(1);
        checks++; if (round_state !== 2'd0) begin failures++; $display("[TB] FAIL start_latency_state: got %0d expected 0", round_state); end
        checks++; if (start !== 1'b0) begin failures++; $display("[TB] FAIL start_latency_pulse: got %0d expected 0", start); end
        tick(1);
        checks++; if (start !== 1'b1) begin failures++; $display("[TB] FAIL start_pulse: got %0d expected 1", start); end
        checks++; if (round_state !== 2'd1) begin failures++; $display("[TB] FAIL start_state: got %0d expected 1", round_state); end
        checks++; if (one_health !== 7'd100) begin failures++; $display("[TB] FAIL start_one_health: got %0d expected 100", one_health); end
        checks++; if (two_health !== 7'd100) begin failures++; $display("[TB] FAIL start_two_health: got %0d expected 100", two_health); end
        checks++; if (time_left !== exp_tl) begin failures++; $display("[TB] FAIL start_time_left: got %0d expected %0d", time_left, exp_tl); end
        tick(1);
        checks++; if (start !== 1'b0) begin failures++; $display("[TB] FAIL start_one_cycle: got %0d expected 0", start); end
        // a second press mid-fight must not restart the round
        start_btn = 1'b0;
        tick(2);
        start_btn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++; if (start !== 1'b0) begin failures++; $display("[TB] FAIL fight_start_ignored cyc%0d: got %0d expected 0", i, start); end
            checks++; if (round_state !== 2'd1) begin failures++; $display("[TB] FAIL fight_state_kept cyc%0d: got %0d expected 1", i, round_state); end
        end
        start_btn = 1'b0;
        tick(2);
    endtask

    task automatic test_iframe();
        one_hit = 1'b1;
        tick(1);
        checks++; if (one_health !== 7'd100) begin failures++; $display("[TB] FAIL hit_latency: got %0d expected 100", one_health); end
        tick(1);
        checks++; if (one_health !== 7'd90) begin failures++; $display("[TB] FAIL hit_first: got %0d expected 90", one_health); end
        tick(38);
        checks++; if (one_health !== 7'd90) begin failures++; $display("[TB] FAIL hit_held_once: got %0d expected 90", one_health); end
        checks++; if (two_health !== 7'd100) begin failures++; $display("[TB] FAIL hit_independent: got %0d expected 100", two_health); end
        one_hit = 1'b0;
        tick(1);
        one_hit = 1'b1;
        tick(1);
        one_hit = 1'b0;
        tick(1);
        checks++; if (one_health !== 7'd80) begin failures++; $display("[TB] FAIL hit_repulse: got %0d expected 80", one_health); end
        // this edge lands on the last cooldown cycle and must be dropped
        tick(14);
        one_hit = 1'b1;
        tick(1);
        one_hit = 1'b0;
        tick(2);
        checks++; if (one_health !== 7'd80) begin failures++; $display("[TB] FAIL hit_in_cooldown: got %0d expected 80", one_health); end
        one_hit = 1'b1;
        tick(1);
        one_hit = 1'b0;
        tick(1);
        checks++; if (one_health !== 7'd70) begin failures++; $display("[TB] FAIL hit_after_cooldown: got %0d expected 70", one_health); end
        tick(20);
    endtask

    task automatic test_ko();
        for (int i = 0; i < 9; i++) begin
            two_hit = 1'b1;
            tick(1);
            two_hit = 1'b0;
            tick(1);
            checks++; if (two_health !== 7'(90 - 10 * i)) begin failures++; $display("[TB] FAIL ko_step%0d: got %0d expected %0d", i, two_health, 90 - 10 * i); end
            tick(18);
        end
        two_hit = 1'b1;
        tick(1);
        two_hit = 1'b0;
        tick(1);
        checks++; if (two_health !== 7'd0) begin failures++; $display("[TB] FAIL ko_zero: got %0d expected 0", two_health); end
        checks++; if (round_state !== 2'd1) begin failures++; $display("[TB] FAIL ko_still_fight: got %0d expected 1", round_state); end
        tick(1);
        checks++; if (round_state !== 2'd2) begin failures++; $display("[TB] FAIL ko_over: got %0d expected 2", round_state); end
        checks++; if (winner !== 2'd1) begin failures++; $display("[TB] FAIL ko_winner: got %0d expected 1", winner); end
        one_hit = 1'b1; two_hit = 1'b1;
        tick(1);
        one_hit = 1'b0; two_hit = 1'b0;
        tick(4);
        checks++; if (one_health !== 7'd70) begin failures++; $display("[TB] FAIL over_one_frozen: got %0d expected 70", one_health); end
        checks++; if (two_health !== 7'd0) begin failures++; $display("[TB] FAIL over_two_frozen: got %0d expected 0", two_health); end
        checks++; if (round_state !== 2'd2) begin failures++; $display("[TB] FAIL over_state_held: got %0d expected 2", round_state); end
        tick(20);
    endtask

    task automatic test_draw();
        start_btn = 1'b1;
        tick(1);
        checks++; if (winner !== 2'd1) begin failures++; $display("[TB] FAIL over_winner_held: got %0d expected 1", winner); end
        start_btn = 1'b0;
        tick(1);
        checks++; if (start !== 1'b1) begin failures++; $display("[TB] FAIL restart_pulse: got %0d expected 1", start); end
        checks++; if (round_state !== 2'd1) begin failures++; $display("[TB] FAIL restart_state: got %0d expected 1", round_state); end
        checks++; if (winner !== 2'd0) begin failures++; $display("[TB] FAIL restart_winner: got %0d expected 0", winner); end
        checks++; if (one_health !== 7'd100 || two_health !== 7'd100) begin failures++; $display("[TB] FAIL restart_health: got %0d/%0d expected 100/100", one_health, two_health); end
        tick(2);
        for (int i = 0; i < 9; i++) begin
            one_hit = 1'b1; two_hit = 1'b1;
            tick(1);
            one_hit = 1'b0; two_hit = 1'b0;
            tick(1);
            checks++; if (one_health !== 7'(90 - 10 * i) || two_health !== 7'(90 - 10 * i)) begin failures++; $display("[TB] FAIL draw_step%0d: got %0d/%0d expected %0d", i, one_health, two_health, 90 - 10 * i); end
            tick(18);
        end
        one_hit = 1'b1; two_hit = 1'b1;
        tick(1);
        one_hit = 1'b0; two_hit = 1'b0;
        tick(1);
        checks++; if (one_health !== 7'd0 || two_health !== 7'd0) begin failures++; $display("[TB] FAIL draw_zero: got %0d/%0d expected 0/0", one_health, two_health); end
        tick(1);
        checks++; if (round_state !== 2'd2) begin failures++; $display("[TB] FAIL draw_over: got %0d expected 2", round_state); end
        checks++; if (winner !== 2'd3) begin failures++; $display("[TB] FAIL draw_winner: got %0d expected 3", winner); end
        tick(2);
    endtask

    task automatic test_reset_mid_fight();
        start_btn = 1'b1;
        tick(1);
        start_btn = 1'b0;
        tick(3);
        for (int i = 0; i < 5; i++) begin
            one_hit = 1'b1;
            tick(1);
            one_hit = 1'b0;
            tick(19);
        end
        checks++; if (one_health !== 7'd50) begin failures++; $display("[TB] FAIL pre_reset_health: got %0d expected 50", one_health); end
        #3;
        rst_n = 1'b0;
        one_hit = 1'b1; start_btn = 1'b1;
        #1;
        checks++; if (round_state !== 2'd0) begin failures++; $display("[TB] FAIL async_reset_state: got %0d expected 0", round_state); end
        checks++; if (one_health !== 7'd100 || two_health !== 7'd100) begin failures++; $display("[TB] FAIL async_reset_health: got %0d/%0d expected 100/100", one_health, two_health); end
        checks++; if (winner !== 2'd0) begin failures++; $display("[TB] FAIL async_reset_winner: got %0d expected 0", winner); end
        tick(2);
        rst_n = 1'b1;
        tick(4);
        checks++; if (round_state !== 2'd0) begin failures++; $display("[TB] FAIL held_start_no_edge: got %0d expected 0", round_state); end
        checks++; if (start !== 1'b0) begin failures++; $display("[TB] FAIL held_start_no_pulse: got %0d expected 0", start); end
        checks++; if (one_health !== 7'd100) begin failures++; $display("[TB] FAIL held_hit_no_edge: got %0d expected 100", one_health); end
        one_hit = 1'b0; start_btn = 1'b0;
        tick(2);
    endtask

`ifdef ROUND_TIMER_EN
    task automatic test_timer();
        start_btn = 1'b1;
        tick(1);
        start_btn = 1'b0;
        tick(1);
        checks++; if (time_left !== 8'd3) begin failures++; $display("[TB] FAIL timer_load: got %0d expected 3", time_left); end
        one_hit = 1'b1;
        tick(1);
        one_hit = 1'b0;
        tick(1);
        checks++; if (one_health !== 7'd90) begin failures++; $display("[TB] FAIL timer_hit: got %0d expected 90", one_health); end
        tick(10);
        checks++; if (round_state !== 2'd1) begin failures++; $display("[TB] FAIL timer_still_fight: got %0d expected 1", round_state); end
        checks++; if (time_left !== 8'd0) begin failures++; $display("[TB] FAIL timer_expired: got %0d expected 0", time_left); end
        tick(1);
        checks++; if (round_state !== 2'd2) begin failures++; $display("[TB] FAIL timer_over: got %0d expected 2", round_state); end
        checks++; if (winner !== 2'd2) begin failures++; $display("[TB] FAIL timer_winner: got %0d expected 2", winner); end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_start();
        test_iframe();
        test_ko();
        test_draw();
        test_reset_mid_fight();
`ifdef ROUND_TIMER_EN
        test_timer();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
